// File: rtl/down_timer_reload.sv
// Programmable down counter with a one-cycle terminal-count pulse and an optional
// auto-reload mode. It can be used as a delay timer or as a divide-by-(N+1) tick source.
module down_timer_reload #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] reload_reg, reload_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      q_reg      <= '0;
      reload_reg <= '0;
    end else begin
      state_reg  <= state_next;
      q_reg      <= q_next;
      reload_reg <= reload_next;
    end
  end

  // A load overrides the state machine. A zero load value parks the counter
  // in IDLE, so the counter never enters RUN with q == 0.
  always_comb begin
    state_next  = state_reg;
    q_next      = q_reg;
    reload_next = reload_reg;
    if (load) begin
      reload_next = load_val;
      q_next      = load_val;
      state_next  = (load_val != '0) ? RUN : IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
        end
        RUN: begin
          if (en) begin
            if (q_reg > WIDTH'(1)) begin
              q_next = q_reg - WIDTH'(1);
            end else begin
              q_next     = '0;
              state_next = DONE;
            end
          end
        end
        DONE: begin
          if (auto_reload && (reload_reg != '0)) begin
            q_next     = reload_reg;
            state_next = RUN;
          end else begin
            q_next     = '0;
            state_next = IDLE;
          end
        end
        default: begin
          q_next     = '0;
          state_next = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    q    = q_reg;
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_down_timer_reload.sv
// Testbench for down_timer_reload. Per-cycle vectors are applied from a table.
// Expected outputs pass through a scoreboard queue, and hand-written sequences cover asynchronous reset.
module tb_down_timer_reload;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         auto_reload;
  logic [W-1:0] q;
  logic         busy;
  logic         done;

  down_timer_reload #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
    .auto_reload (auto_reload),
    .q           (q),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         ld;
    logic [W-1:0] lv;
    logic         en;
    logic         ar;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input int ld, input int lv, input int e, input int ar,
                     input int eq, input int eb, input int ed);
    vec_t v;
    v.ld   = ld[0];
    v.lv   = W'(lv);
    v.en   = e[0];
    v.ar   = ar[0];
    v.q    = W'(eq);
    v.busy = eb[0];
    v.done = ed[0];
    vecs.push_back(v);
  endtask

  task automatic expect_out(input int eq, input int eb, input int ed);
    exp_t x;
    x.q    = W'(eq);
    x.busy = eb[0];
    x.done = ed[0];
    sb.push_back(x);
  endtask

  task automatic check(input string name, input int idx);
    exp_t x;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s #%0d: scoreboard empty, got q=%0d busy=%0b done=%0b", name, idx, q, busy, done);
      return;
    end
    x = sb.pop_front();
    $display("[TB] %s #%0d q=%0d busy=%0b done=%0b (want q=%0d busy=%0b done=%0b)",
             name, idx, q, busy, done, x.q, x.busy, x.done);
    if (q !== x.q || busy !== x.busy || done !== x.done) begin
      n_fail++;
      $display("FAIL %s #%0d: got q=%0d busy=%0b done=%0b, required q=%0d busy=%0b done=%0b",
               name, idx, q, busy, done, x.q, x.busy, x.done);
    end
  endtask

  initial begin
    // One-shot count of 5.
    add(1, 5, 1, 0, 5, 1, 0);
    add(0, 0, 1, 0, 4, 1, 0);
    add(0, 0, 1, 0, 3, 1, 0);
    add(0, 0, 1, 0, 2, 1, 0);
    add(0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0);
    // Auto-reload of 3, with a period of 4.
    add(1, 3, 1, 1, 3, 1, 0);
    add(0, 0, 1, 1, 2, 1, 0);
    add(0, 0, 1, 1, 1, 1, 0);
    add(0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 1, 1, 3, 1, 0);
    add(0, 0, 1, 1, 2, 1, 0);
    add(0, 0, 1, 1, 1, 1, 0);
    add(0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 1, 1, 3, 1, 0);
    // Enable gap at q=3.
    add(1, 4, 1, 0, 4, 1, 0);
    add(0, 0, 1, 0, 3, 1, 0);
    add(0, 0, 0, 0, 3, 1, 0);
    add(0, 0, 0, 0, 3, 1, 0);
    add(0, 0, 0, 0, 3, 1, 0);
    add(0, 0, 1, 0, 2, 1, 0);
    add(0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0);
    // Reload in RUN at q=6, then load of zero in RUN.
    add(1, 7, 1, 0, 7, 1, 0);
    add(0, 0, 1, 0, 6, 1, 0);
    add(1, 2, 1, 0, 2, 1, 0);
    add(0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0);
    add(1, 7, 1, 0, 7, 1, 0);
    add(1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0);
    // Maximum count: 16 edges from load to done, with no wrap.
    add(1, 15, 1, 0, 15, 1, 0);
    for (int v = 14; v >= 1; v--) add(0, 0, 1, 0, v, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0);
    // A load in the DONE cycle wins over the reload.
    add(1, 2, 1, 1, 2, 1, 0);
    add(0, 0, 1, 1, 1, 1, 0);
    add(0, 0, 1, 1, 0, 0, 1);
    add(1, 7, 1, 1, 7, 1, 0);
    add(0, 0, 1, 1, 6, 1, 0);
    // auto_reload is sampled only in DONE.
    add(1, 2, 1, 1, 2, 1, 0);
    add(0, 0, 1, 1, 1, 1, 0);
    add(0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0);
    add(1, 3, 1, 0, 3, 1, 0);
    add(0, 0, 1, 0, 2, 1, 0);
    add(0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 1, 1, 3, 1, 0);

    rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; auto_reload = 1'b0;
    @(negedge clk);
    expect_out(0, 0, 0);
    check("reset", 0);
    load = 1'b1; load_val = 4'd9; en = 1'b1;
    @(posedge clk); #1;
    expect_out(0, 0, 0);
    check("reset_overrides_load", 0);
    @(negedge clk);
    rst = 1'b0; load = 1'b0; load_val = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      load = vecs[i].ld; load_val = vecs[i].lv; en = vecs[i].en; auto_reload = vecs[i].ar;
      expect_out(int'(vecs[i].q), int'(vecs[i].busy), int'(vecs[i].done));
      @(posedge clk); #1;
      check("vec", i);
    end

    // Asynchronous reset in the middle of a count.
    @(negedge clk);
    load = 1'b1; load_val = 4'd7; en = 1'b1; auto_reload = 1'b1;
    expect_out(7, 1, 0);
    @(posedge clk); #1;
    check("arst_setup", 0);
    @(negedge clk);
    load = 1'b0; load_val = '0;
    expect_out(6, 1, 0);
    @(posedge clk); #1;
    check("arst_setup", 1);
    #2 rst = 1'b1;
    #1;
    expect_out(0, 0, 0);
    check("arst_between_edges", 0);
    @(posedge clk); #1;
    expect_out(0, 0, 0);
    check("arst_held", 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_out(0, 0, 0);
      @(posedge clk); #1;
      check("after_arst_idle", i);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
